// File: rtl/lfsr_descramble_stream.sv
// lfsr_descramble_stream: streaming LFSR descrambler with valid/ready on both
// sides, self-synchronous or additive mode, per-beat bypass, run-time seed
// load and a two-entry skid buffer on the output.
// Optional statistics counters: define LFSR_DESCRAMBLE_STREAM_STATS_EN.
module lfsr_descramble_stream #(
  parameter int                    LFSR_WIDTH = 58,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 58'h8000000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = {LFSR_WIDTH{1'b1}},
  parameter string                 MODE       = "SELF_SYNC",
  parameter int                    REVERSE    = 1,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    USER_WIDTH = 2,
  parameter string                 STYLE      = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [USER_WIDTH-1:0] s_user,
  input  logic                  s_bypass,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [USER_WIDTH-1:0] m_user,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_bypass
`endif
);

  localparam int N        = LFSR_WIDTH + DATA_WIDTH;
  localparam bit ADDITIVE = (MODE == "ADDITIVE");
  // Self-sync shifts the received bit into the state; additive shifts in feedback.
  localparam bit FEED_FWD = !ADDITIVE;

  // Symbolic unrolling of DATA_WIDTH shifts. Row r is the XOR mask over
  // {data_in, state} for output r of {data_out, state_out}.
  function automatic logic [N-1:0][N-1:0] build_masks();
    logic [LFSR_WIDTH-1:0][N-1:0] st;
    logic [N-1:0][N-1:0]          res;
    logic [N-1:0]                 fb, dm, o;
    int                           k;
    res = '0;
    for (int b = 0; b < LFSR_WIDTH; b++) begin
      st[b]    = '0;
      st[b][b] = 1'b1;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      k  = (REVERSE != 0) ? i : DATA_WIDTH - 1 - i;
      fb = st[LFSR_WIDTH-1];
      for (int j = 1; j < LFSR_WIDTH; j++)
        if (LFSR_POLY[j]) fb = fb ^ st[j-1];
      dm = '0;
      dm[LFSR_WIDTH+k] = 1'b1;
      o  = fb ^ dm;
      res[LFSR_WIDTH+k] = o;
      st = {st[LFSR_WIDTH-2:0], FEED_FWD ? dm : o};
    end
    for (int b = 0; b < LFSR_WIDTH; b++) res[b] = st[b];
    return res;
  endfunction

  // Bit-serial evaluation of the same recurrence; returns {data_out, state_out}.
  function automatic logic [N-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] st_in,
                                             input logic [DATA_WIDTH-1:0] din);
    logic [LFSR_WIDTH-1:0] st;
    logic [DATA_WIDTH-1:0] dout;
    logic                  fb, o;
    int                    k;
    st   = st_in;
    dout = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      k  = (REVERSE != 0) ? i : DATA_WIDTH - 1 - i;
      fb = st[LFSR_WIDTH-1];
      for (int j = 1; j < LFSR_WIDTH; j++)
        if (LFSR_POLY[j]) fb = fb ^ st[j-1];
      o       = fb ^ din[k];
      dout[k] = o;
      st      = {st[LFSR_WIDTH-2:0], FEED_FWD ? din[k] : o};
    end
    return {dout, st};
  endfunction

  logic [LFSR_WIDTH-1:0] state_reg, state_next;
  logic [DATA_WIDTH-1:0] core_data_in, core_data_out, beat_data;
  logic [LFSR_WIDTH-1:0] core_state_out;
  logic [N-1:0]          core_out;
  logic                  accept, stall, skid_valid_next;
  logic                  out_valid_reg, skid_valid_reg, s_ready_reg;
  logic [DATA_WIDTH-1:0] out_data_reg, skid_data_reg;
  logic [USER_WIDTH-1:0] out_user_reg, skid_user_reg;
  logic                  out_last_reg, skid_last_reg;

  assign accept       = s_valid && s_ready_reg;
  assign stall        = out_valid_reg && !m_ready;
  assign core_data_in = ADDITIVE ? '0 : s_data;
  assign {core_data_out, core_state_out} = core_out;

  generate
    if (STYLE == "LOOP") begin : g_loop
      // Serial recurrence, left for synthesis to flatten.
      always_comb core_out = lfsr_step(state_reg, core_data_in);
    end else begin : g_reduce
      localparam logic [N-1:0][N-1:0] MASKS = build_masks();
      logic [N-1:0] core_in;
      assign core_in = {core_data_in, state_reg};
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign core_out[gi] = ^(MASKS[gi] & core_in);
      end
    end
  endgenerate

  // Descrambled value of the beat being accepted; bypass passes it through.
  always_comb begin
    if (s_bypass)      beat_data = s_data;
    else if (ADDITIVE) beat_data = s_data ^ core_data_out;
    else               beat_data = core_data_out;
  end

  // LFSR next state: seed beats frame restart beats normal advance.
  always_comb begin
    state_next = state_reg;
    if (seed_load)                         state_next = seed_value;
    else if (ADDITIVE && accept && s_last) state_next = LFSR_INIT;
    else if (accept && !s_bypass)          state_next = core_state_out;
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= LFSR_INIT;
    else        state_reg <= state_next;
  end

  // Skid stays (or becomes) occupied only while the output register is stalled.
  always_comb skid_valid_next = stall ? (skid_valid_reg || accept) : 1'b0;

  // Output register plus skid register; s_ready is registered from skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_user_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_user_reg  <= '0;
      skid_last_reg  <= 1'b0;
      s_ready_reg    <= 1'b0;
    end else begin
      if (!stall) begin
        if (skid_valid_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= skid_data_reg;
          out_user_reg  <= skid_user_reg;
          out_last_reg  <= skid_last_reg;
        end else if (accept) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= beat_data;
          out_user_reg  <= s_user;
          out_last_reg  <= s_last;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        skid_data_reg <= beat_data;
        skid_user_reg <= s_user;
        skid_last_reg <= s_last;
      end
      skid_valid_reg <= skid_valid_next;
      s_ready_reg    <= !skid_valid_next;
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = out_valid_reg;
  assign m_data  = out_data_reg;
  assign m_user  = out_user_reg;
  assign m_last  = out_last_reg;

`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
  logic [31:0] stat_beats_reg, stat_bypass_reg;

  // Saturating beat counters; clear takes precedence over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_reg  <= '0;
      stat_bypass_reg <= '0;
    end else if (stat_clear) begin
      stat_beats_reg  <= '0;
      stat_bypass_reg <= '0;
    end else begin
      if (accept && stat_beats_reg != 32'hFFFF_FFFF)
        stat_beats_reg <= stat_beats_reg + 32'd1;
      if (accept && s_bypass && stat_bypass_reg != 32'hFFFF_FFFF)
        stat_bypass_reg <= stat_bypass_reg + 32'd1;
    end
  end

  assign stat_beats  = stat_beats_reg;
  assign stat_bypass = stat_bypass_reg;
`endif

endmodule

// File: tb/tb_lfsr_descramble_stream.sv
// Testbench for lfsr_descramble_stream: a SELF_SYNC instance fed by a bit-serial
// x^58+x^39+1 scrambler model, and an ADDITIVE instance checked against the
// keystream of the same recurrence. Expected beats go through scoreboard queues.
`timescale 1ns/1ps
module tb_lfsr_descramble_stream;
  localparam int W = 58;
  localparam int D = 64;
  localparam int U = 2;
  localparam logic [W-1:0] INIT = {W{1'b1}};

  typedef struct packed {
    logic [D-1:0] data;
    logic [U-1:0] user;
    logic         last;
    logic         dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [D-1:0] s_data, m_data, a_s_data, a_m_data;
  logic [U-1:0] s_user, m_user, a_s_user, a_m_user;
  logic         s_bypass, s_last, s_valid, s_ready, seed_load;
  logic [W-1:0] seed_value;
  logic         m_last, m_valid, m_ready;
  logic         a_s_last, a_s_valid, a_s_ready, a_m_last, a_m_valid, a_m_ready;
`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
  logic         stat_clear;
  logic [31:0]  stat_beats, stat_bypass, a_stat_beats, a_stat_bypass;
`endif

  int   tests = 0;
  int   fails = 0;
  int   n_acc = 0;
  int   n_byp = 0;
  bit   lat_chk = 1'b0;
  exp_t q[$];
  exp_t qa[$];
  logic [W-1:0] mst;

  lfsr_descramble_stream #(.MODE("SELF_SYNC")) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_user(s_user), .s_bypass(s_bypass), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready),
    .seed_load(seed_load), .seed_value(seed_value),
    .m_data(m_data), .m_user(m_user), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
    , .stat_clear(stat_clear), .stat_beats(stat_beats), .stat_bypass(stat_bypass)
`endif
  );

  lfsr_descramble_stream #(.MODE("ADDITIVE")) dut_add (
    .clk(clk), .rst_n(rst_n),
    .s_data(a_s_data), .s_user(a_s_user), .s_bypass(1'b0), .s_last(a_s_last),
    .s_valid(a_s_valid), .s_ready(a_s_ready),
    .seed_load(1'b0), .seed_value({W{1'b0}}),
    .m_data(a_m_data), .m_user(a_m_user), .m_last(a_m_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready)
`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
    , .stat_clear(1'b0), .stat_beats(a_stat_beats), .stat_bypass(a_stat_bypass)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference scrambler: LSB first, feedback s[57]^s[38], scrambled bit shifted in.
  task automatic scramble(input logic [D-1:0] d, input logic [W-1:0] si,
                          output logic [D-1:0] c, output logic [W-1:0] so);
    logic [W-1:0] s;
    logic         b;
    s = si;
    for (int i = 0; i < D; i++) begin
      b    = s[57] ^ s[38] ^ d[i];
      c[i] = b;
      s    = {s[56:0], b};
    end
    so = s;
  endtask

  // Hold a beat on the input until accepted (bounded wait).
  task automatic drive(input logic [D-1:0] d, input logic [U-1:0] u,
                       input logic byp, input logic last);
    logic r;
    int   waited;
    waited   = 0;
    r        = 1'b0;
    s_data   = d;
    s_user   = u;
    s_bypass = byp;
    s_last   = last;
    s_valid  = 1'b1;
    forever begin
      @(negedge clk);
      r = s_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waited++;
      if (waited > 50) begin
        tests++;
        fails++;
        $error("FAIL drive_timeout observed=s_ready_low expected=accept");
        break;
      end
    end
    s_valid  = 1'b0;
    s_bypass = 1'b0;
    s_last   = 1'b0;
    if (r) begin
      n_acc++;
      if (byp) n_byp++;
      if (lat_chk) chk("latency_m_valid", 64'(m_valid), 64'd1);
    end
  endtask

  // Scramble a plain beat with the model, expect the plain beat back.
  task automatic send(input logic [D-1:0] p, input logic [U-1:0] u,
                      input logic last, input logic dc);
    logic [D-1:0] c;
    logic [W-1:0] ns;
    exp_t         e;
    scramble(p, mst, c, ns);
    e.data = p; e.user = u; e.last = last; e.dc = dc;
    q.push_back(e);
    drive(c, u, 1'b0, last);
    mst = ns;
  endtask

  function automatic logic [D-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard for the SELF_SYNC instance: compare on each output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (m_valid && m_ready) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected observed=extra_beat data=0x%0h expected=no_beat", m_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        if (!e.dc) chk("sb_data", m_data, e.data);
        chk("sb_user", 64'(m_user), 64'(e.user));
        chk("sb_last", 64'(m_last), 64'(e.last));
      end
    end
  end

  // Scoreboard for the ADDITIVE instance.
  always @(negedge clk) begin
    exp_t e;
    if (a_m_valid && a_m_ready) begin
      tests++;
      assert (qa.size() != 0) else begin
        fails++;
        $error("FAIL add_unexpected observed=extra_beat data=0x%0h expected=no_beat", a_m_data);
      end
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("add_data", a_m_data, e.data);
        chk("add_last", 64'(a_m_last), 64'(e.last));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] c, p1, plain;
    logic [W-1:0] ns, ast;
    logic         r;
    int           acc_cnt;
    exp_t         e;

    s_data = '0; s_user = '0; s_bypass = 1'b0; s_last = 1'b0; s_valid = 1'b0;
    seed_load = 1'b0; seed_value = '0; m_ready = 1'b1;
    a_s_data = '0; a_s_user = '0; a_s_last = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b1;
`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
    stat_clear = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_user", 64'(m_user), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_s_ready", 64'(s_ready), 64'd1);
    chk("rst_release_add_s_ready", 64'(a_s_ready), 64'd1);

    // 1000 random beats, matching init, m_ready high
    mst = INIT;
    lat_chk = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(rnd64(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    lat_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("random_drained", 64'(q.size()), 64'd0);

    // Descrambler seeded to zero, scrambler at all ones: first beat don't-care
    seed_value = '0;
    seed_load  = 1'b1;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    mst = INIT;
    send(rnd64(), 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) send(rnd64(), 2'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("seed0_drained", 64'(q.size()), 64'd0);

    // ADDITIVE: two 4-beat zero frames, keystream restarts after each last
    for (int f = 0; f < 2; f++) begin
      ast = INIT;
      for (int b = 0; b < 4; b++) begin
        scramble('0, ast, c, ns);
        ast = ns;
        e.data = c; e.user = 2'(b); e.last = (b == 3); e.dc = 1'b0;
        qa.push_back(e);
        a_s_data = '0; a_s_user = 2'(b); a_s_last = (b == 3); a_s_valid = 1'b1;
        @(negedge clk);
        chk("add_s_ready", 64'(a_s_ready), 64'd1);
        @(posedge clk);
        #1;
      end
    end
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("add_drained", 64'(qa.size()), 64'd0);

    // Backpressure: 5 cycles of s_valid with m_ready low
    m_ready = 1'b0;
    acc_cnt = 0;
    plain = rnd64();
    p1 = plain;
    scramble(plain, mst, c, ns);
    s_data = c; s_user = 2'd3; s_last = 1'b0; s_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      r = s_ready;
      if (acc_cnt == 2) chk("bp_s_ready_low", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      if (r) begin
        e.data = plain; e.user = 2'd3; e.last = 1'b0; e.dc = 1'b0;
        q.push_back(e);
        mst = ns;
        acc_cnt++;
        n_acc++;
        plain = rnd64();
        scramble(plain, mst, c, ns);
        s_data = c;
      end
    end
    s_valid = 1'b0;
    chk("bp_accept_count", 64'(acc_cnt), 64'd2);
    chk("bp_m_valid_held", 64'(m_valid), 64'd1);
    chk("bp_m_data_held", m_data, p1);
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Bypass beat between two normal beats
    send(rnd64(), 2'd0, 1'b0, 1'b0);
    plain = rnd64();
    e.data = plain; e.user = 2'd2; e.last = 1'b1; e.dc = 1'b0;
    q.push_back(e);
    drive(plain, 2'd2, 1'b1, 1'b1);
    send(rnd64(), 2'd1, 1'b0, 1'b0);

    // Seed load together with an accept: that beat uses the old state
    seed_value = 58'h1;
    seed_load  = 1'b1;
    send(rnd64(), 2'd0, 1'b0, 1'b0);
    seed_load = 1'b0;
    mst = 58'h1;
    send(rnd64(), 2'd1, 1'b0, 1'b0);
    send(rnd64(), 2'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("seed_drained", 64'(q.size()), 64'd0);

`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
    chk("stat_beats", 64'(stat_beats), 64'(n_acc));
    chk("stat_bypass", 64'(stat_bypass), 64'(n_byp));
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    chk("stat_beats_clear", 64'(stat_beats), 64'd0);
    chk("stat_bypass_clear", 64'(stat_bypass), 64'd0);
`endif

    // Reset with two beats buffered
    m_ready = 1'b0;
    send(rnd64(), 2'd1, 1'b0, 1'b0);
    send(rnd64(), 2'd2, 1'b1, 1'b0);
    chk("pre_rst_s_ready", 64'(s_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_data", m_data, 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
`ifdef LFSR_DESCRAMBLE_STREAM_STATS_EN
    chk("midrst_stat_beats", 64'(stat_beats), 64'd0);
    chk("midrst_stat_bypass", 64'(stat_bypass), 64'd0);
`endif
    q.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_s_ready", 64'(s_ready), 64'd1);
    mst = INIT;
    for (int i = 0; i < 3; i++) send(rnd64(), 2'd3, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_descramble_stream.md
# lfsr_descramble_stream

Streaming LFSR descrambler with valid/ready flow control on both sides, for the receive datapath between the block aligner (64b66b / 128b130b) and the decoder. Generalises the free-running descrambler in four ways: backpressure, self-synchronous or additive mode, per-beat bypass, and run-time seed load. The unrolled next-state and output logic comes from the existing combinational `lfsr` core; this block adds the state register, the handshake and a skid buffer.

## Interface
- LFSR_WIDTH, 58, LFSR register width
- LFSR_POLY, 58'h8000000001, polynomial without the top term
- LFSR_INIT, all ones, state after reset and after frame end in ADDITIVE mode
- MODE, "SELF_SYNC", "SELF_SYNC" (feed-forward Fibonacci) or "ADDITIVE" (keystream XOR, Fibonacci)
- REVERSE, 1, bit-reverse LFSR input and output
- DATA_WIDTH, 64, data beat width; one LFSR shift per bit
- USER_WIDTH, 2, sideband width (e.g. sync header), passed through unchanged
- STYLE, "AUTO", passed to the `lfsr` core
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  DATA_WIDTH  scrambled input beat
- s_user  in  USER_WIDTH  input sideband
- s_bypass  in  1  beat passes unmodified; LFSR state holds
- s_last  in  1  last beat of frame
- s_valid / s_ready  in / out  1  input handshake
- seed_load  in  1  load seed_value into state (single-cycle pulse)
- seed_value  in  LFSR_WIDTH  seed
- m_data / m_user / m_last  out  DATA_WIDTH / USER_WIDTH / 1  output beat
- m_valid / m_ready  out / in  1  output handshake

## Operation
- Beat accepted when s_valid && s_ready.
- SELF_SYNC: `lfsr` core runs as FIBONACCI_FF, data_in = s_data, m_data = core data_out, next state = core state_out.
- ADDITIVE: `lfsr` core runs as FIBONACCI, data_in = 0, m_data = s_data ^ core data_out, next state = core state_out.
- Bypass beat: m_data = s_data, state unchanged; m_user and m_last still pass through.
- Next-state priority, highest first:
  1. seed_load: state <= seed_value. The beat accepted in the same cycle, if any, still uses the old state.
  2. ADDITIVE and accepted beat with s_last = 1: state <= LFSR_INIT. The bypass flag does not matter.
  3. Accepted non-bypass beat: state <= core state_out.
  4. Otherwise hold.
- Output path: two-entry skid buffer (output register + skid register).
  - s_ready = !skid_valid, driven from a register.
  - Accepted beat while the output register is stalled (m_valid && !m_ready) goes to skid.
  - On output drain, skid moves to the output register.
- The descrambled value is computed at accept time. Buffered beats are never recomputed.

## Timing
- Latency: 1 cycle from accept to m_valid.
- Throughput: 1 beat/cycle when m_ready = 1.
- Reset (rst_n low, asynchronous):
  - state = LFSR_INIT.
  - m_valid = 0, m_data = 0, m_user = 0, m_last = 0.
  - skid empty; s_ready = 0 while rst_n is low, 1 on the first clock after release.
- Reset mid-operation: buffered beats are discarded and no partial beat is emitted.
- Full buffer: at most 2 beats outstanding; s_ready low the cycle after skid fills.
- Empty buffer: m_valid low; m_data holds its last value.
- Simultaneous drain and accept: throughput is kept. With the skid empty, the new beat goes straight to the output register.
- m_data, m_user, m_last are stable while m_valid && !m_ready.

## Configuration
- LFSR_DESCRAMBLE_STREAM_STATS_EN defined:
  - adds ports stat_clear (in, 1), stat_beats (out, 32) and stat_bypass (out, 32).
  - stat_beats counts all accepted beats; stat_bypass counts accepted bypass beats.
  - Both counters saturate at 32'hFFFFFFFF, reset to 0 and clear synchronously on stat_clear. Clear wins over increment in the same cycle.
- Undefined: no stat ports and no counter logic.

## Test plan
- SELF_SYNC, matching init: 1000 random beats through the `lfsr` scrambler model (same parameters), m_ready = 1 -> m_data equals the original on every beat, m_valid 1 cycle after each accept.
- SELF_SYNC, descrambler seeded 58'h0 and scrambler seeded all ones -> beat 0 may differ, beats 1..N match, because 58 < 64 bits flush the state.
- ADDITIVE: two 4-beat frames of all-zero data, s_last on beats 3 and 7 -> beats 4..7 equal beats 0..3 (keystream restarts at LFSR_INIT).
- Backpressure:
  - s_valid = 1 with m_ready = 0 for 5 cycles -> exactly 2 beats accepted, s_ready = 0 from the cycle after the second accept.
  - m_ready = 1 -> both beats out in order, no loss or duplication.
- Bypass and seed:
  - beat with s_bypass = 1 between two normal beats -> data unchanged, following beat identical to a run without the bypass beat.
  - seed_load with seed_value = 58'h1 together with an accept -> that beat uses the old state, the next beat uses 58'h1.
- rst_n asserted with 2 beats buffered -> m_valid = 0 immediately, state = LFSR_INIT; with STATS_EN, both counters = 0.
